tmds_channel_decoder: RTL and testbench

Receive-side counterpart of the DVI/HDMI transmit path: recovers 8-bit pixel data, the 2 control bits and data-enable from one TMDS channel. Input is the 10-bit parallel word per pixel clock from the channel deserializer. The block word-aligns the stream by hunting for control tokens and pulsing a bitslip request to the deserializer, then decodes in a 2-stage pipeline. Three instances, one per channel (blue carries hsync/vsync), feed a downstream channel-deskew and video-timing recovery stage.

---
 rtl/tmds_pkg.sv | 51 +++++
 rtl/tmds_channel_decoder_if.sv | 22 ++
 rtl/tmds_word_align.sv | 111 +++++++++++
 rtl/tmds_channel_decoder.sv | 52 +++++
 tb/tb_tmds_channel_decoder.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS sink definitions: control tokens, alignment FSM states and the
// per-word decode function used by every TMDS receive block.
package tmds_pkg;

    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_SLIP,
        ST_SETTLE,
        ST_LOCKED
    } align_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       de;
        logic       ctrl_valid;
    } tmds_dec_t;

    function automatic logic tmds_is_token(input logic [9:0] q);
        return (q == TOK_C00) || (q == TOK_C01) || (q == TOK_C10) || (q == TOK_C11);
    endfunction

    // ctrl_prev is carried through on data words so ctrl holds between tokens
    function automatic tmds_dec_t tmds_decode_word(input logic [9:0] q,
                                                   input logic [1:0] ctrl_prev);
        tmds_dec_t  r;
        logic [7:0] v;
        r      = '0;
        r.ctrl = ctrl_prev;
        v      = q[9] ? ~q[7:0] : q[7:0];
        case (q)
            TOK_C00: begin r.ctrl = 2'b00; r.ctrl_valid = 1'b1; end
            TOK_C01: begin r.ctrl = 2'b01; r.ctrl_valid = 1'b1; end
            TOK_C10: begin r.ctrl = 2'b10; r.ctrl_valid = 1'b1; end
            TOK_C11: begin r.ctrl = 2'b11; r.ctrl_valid = 1'b1; end
            default: begin
                r.de      = 1'b1;
                r.data[0] = v[0];
                for (int i = 1; i < 8; i++)
                    r.data[i] = q[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tmds_channel_decoder_if.sv
// One TMDS channel between the deserializer (master) and the channel decoder (slave).
interface tmds_channel_decoder_if;

    logic [9:0] tmds_word;
    logic       bitslip;
    logic       locked;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
    logic       ctrl_valid;

    modport master (
        output tmds_word,
        input  bitslip, locked, data, ctrl, de, ctrl_valid
    );

    modport slave (
        input  tmds_word,
        output bitslip, locked, data, ctrl, de, ctrl_valid
    );

endinterface

// File: rtl/tmds_word_align.sv
// Word-alignment FSM: hunts for control-token runs, requests bitslips while
// unaligned and tracks loss of alignment once locked.
module tmds_word_align
    import tmds_pkg::*;
#(
    parameter int unsigned LOCK_TOKENS   = 8,
    parameter int unsigned SEARCH_WINDOW = 2048,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned LOSS_WINDOW   = 4096
) (
    input  logic clk_pix_1x,
    input  logic rst_n,
    input  logic tok_vld,
    output logic bitslip,
    output logic locked
);

    localparam int RUN_W = (LOCK_TOKENS   > 1) ? $clog2(LOCK_TOKENS + 1) : 1;
    localparam int WIN_W = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW)   : 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES)   : 1;
    localparam int LOS_W = (LOSS_WINDOW   > 1) ? $clog2(LOSS_WINDOW)     : 1;

    localparam logic [RUN_W-1:0] RUN_MAX     = RUN_W'(LOCK_TOKENS);
    localparam logic [RUN_W-1:0] RUN_LAST    = RUN_W'(LOCK_TOKENS - 1);
    localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [LOS_W-1:0] LOSS_LAST   = LOS_W'(LOSS_WINDOW - 1);

    align_state_e     state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [LOS_W-1:0] loss_q, loss_d;

    always_ff @(posedge clk_pix_1x or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_SEARCH;
            run_q    <= '0;
            win_q    <= '0;
            settle_q <= '0;
            loss_q   <= '0;
            bitslip  <= 1'b0;
            locked   <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            win_q    <= win_d;
            settle_q <= settle_d;
            loss_q   <= loss_d;
            bitslip  <= (state_d == ST_SLIP);
            locked   <= (state_d == ST_LOCKED);
        end
    end

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        win_d    = win_q;
        settle_d = settle_q;
        loss_d   = loss_q;
        case (state_q)
            ST_SEARCH: begin
                run_d = tok_vld ? run_q + 1'b1 : '0;
                win_d = win_q + 1'b1;
                // a completed run wins over an expiring window on the same cycle
                if (tok_vld && run_q == RUN_LAST) begin
                    state_d = ST_LOCKED;
                    run_d   = RUN_MAX;
                    win_d   = '0;
                    loss_d  = '0;
                end else if (win_q == WIN_LAST) begin
                    state_d = ST_SLIP;
                    win_d   = '0;
                end
            end
            ST_SLIP: begin
                state_d  = ST_SETTLE;
                settle_d = '0;
            end
            ST_SETTLE: begin
                settle_d = settle_q + 1'b1;
                run_d    = '0;
                if (settle_q == SETTLE_LAST) begin
                    state_d  = ST_SEARCH;
                    win_d    = '0;
                    settle_d = '0;
                end
            end
            ST_LOCKED: begin
                if (!tok_vld)
                    run_d = '0;
                else if (run_q >= RUN_LAST)
                    run_d = RUN_MAX;
                else
                    run_d = run_q + 1'b1;
                if (tok_vld && run_q >= RUN_LAST) begin
                    loss_d = '0;
                end else if (loss_q == LOSS_LAST) begin
                    state_d = ST_SEARCH;
                    run_d   = '0;
                    win_d   = '0;
                    loss_d  = '0;
                end else begin
                    loss_d = loss_q + 1'b1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: 2-stage decode pipeline (register word, register
// decoded result) plus the word-alignment controller fed from stage 1.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int unsigned LOCK_TOKENS   = 8,
    parameter int unsigned SEARCH_WINDOW = 2048,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned LOSS_WINDOW   = 4096
) (
    input  logic                   clk_pix_1x,
    input  logic                   rst_n,
    tmds_channel_decoder_if.slave  bus
);

    logic [9:0] s1_word;
    logic       s1_tok;
    tmds_dec_t  s2_d, s2_q;

    always_ff @(posedge clk_pix_1x or negedge rst_n) begin
        if (!rst_n) begin
            s1_word <= '0;
            s2_q    <= '0;
        end else begin
            s1_word <= bus.tmds_word;
            s2_q    <= s2_d;
        end
    end

    assign s2_d   = tmds_decode_word(s1_word, s2_q.ctrl);
    assign s1_tok = tmds_is_token(s1_word);

    assign bus.data       = s2_q.data;
    assign bus.ctrl       = s2_q.ctrl;
    assign bus.de         = s2_q.de;
    assign bus.ctrl_valid = s2_q.ctrl_valid;

    // alignment sees stage 1 so locked lines up with that token's stage-2 output
    tmds_word_align #(
        .LOCK_TOKENS   (LOCK_TOKENS),
        .SEARCH_WINDOW (SEARCH_WINDOW),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .LOSS_WINDOW   (LOSS_WINDOW)
    ) u_align (
        .clk_pix_1x (clk_pix_1x),
        .rst_n      (rst_n),
        .tok_vld    (s1_tok),
        .bitslip    (bus.bitslip),
        .locked     (bus.locked)
    );

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Randomized bench for tmds_channel_decoder against a word-level reference model.
module tb_tmds_channel_decoder;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T11 = 10'b1010101011;

    logic clk_pix_1x = 1'b0;
    logic rst_n      = 1'b0;
    always #5 clk_pix_1x = ~clk_pix_1x;

    tmds_channel_decoder_if bus_if ();

    tmds_channel_decoder dut (
        .clk_pix_1x (clk_pix_1x),
        .rst_n      (rst_n),
        .bus        (bus_if.slave)
    );

    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         n_slip = 0;
    int         slip_cyc [$];
    logic [9:0] w_d1 = '0;
    logic [9:0] w_d2 = '0;
    logic [1:0] exp_ctrl = '0;
    bit         dec_chk = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic int tok_code(input logic [9:0] q);
        logic [9:0] toks [4];
        toks = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
        for (int i = 0; i < 4; i++) if (q == toks[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] ref_data(input logic [9:0] q);
        int v, d, b;
        v = q[9] ? (~int'(q[7:0]) & 8'hff) : int'(q[7:0]);
        d = v & 1;
        for (int i = 1; i < 8; i++) begin
            b = ((v >> i) ^ (v >> (i - 1))) & 1;
            if (!q[8]) b = b ^ 1;
            d = d | (b << i);
        end
        return 8'(d);
    endfunction

    function automatic logic [9:0] rotr(input logic [9:0] w, input int k);
        logic [19:0] t;
        t = {w, w} >> k;
        return t[9:0];
    endfunction

    function automatic logic [9:0] rand_data_word();
        logic [9:0] w;
        do w = 10'($urandom); while (tok_code(w) >= 0);
        return w;
    endfunction

    // Advance one clock; outputs now reflect the word driven two ticks ago.
    task automatic tick();
        int t;
        @(posedge clk_pix_1x);
        #1;
        cyc++;
        w_d2 = w_d1;
        w_d1 = bus_if.tmds_word;
        if (bus_if.bitslip) begin
            n_slip++;
            slip_cyc.push_back(cyc);
        end
        t = tok_code(w_d2);
        if (t >= 0) exp_ctrl = 2'(t);
        if (dec_chk) begin
            chk("dec_data", {24'd0, bus_if.data}, (t >= 0) ? 32'd0 : {24'd0, ref_data(w_d2)});
            chk("dec_de", {31'd0, bus_if.de}, {31'd0, t < 0});
            chk("dec_ctrl_valid", {31'd0, bus_if.ctrl_valid}, {31'd0, t >= 0});
            chk("dec_ctrl", {30'd0, bus_if.ctrl}, {30'd0, exp_ctrl});
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_if.tmds_word = '0;
        dec_chk = 1'b0;
        repeat (3) tick();
        w_d1 = '0;
        w_d2 = '0;
        exp_ctrl = '0;
        rst_n = 1'b1;
    endtask

    // Drive LOCK_TOKENS tokens; locked must rise exactly 2 cycles after the last.
    task automatic run_tokens_lock(input logic [9:0] tok, input string tag);
        for (int k = 0; k < 8; k++) begin
            bus_if.tmds_word = tok;
            tick();
        end
        chk({tag, "_early"}, {31'd0, bus_if.locked}, 32'd0);
        tick();
        chk({tag, "_rise"}, {31'd0, bus_if.locked}, 32'd1);
    endtask

    initial begin
        int off, prev;
        bus_if.tmds_word = '0;

        // lock on aligned input
        do_reset();
        n_slip = 0;
        chk("rst_locked", {31'd0, bus_if.locked}, 32'd0);
        chk("rst_de", {31'd0, bus_if.de}, 32'd0);
        run_tokens_lock(T00, "lock");
        tick();
        chk("lock_ctrl", {30'd0, bus_if.ctrl}, 32'd0);
        chk("lock_ctrl_valid", {31'd0, bus_if.ctrl_valid}, 32'd1);
        chk("lock_de", {31'd0, bus_if.de}, 32'd0);
        chk("lock_no_bitslip", n_slip, 32'd0);

        // directed decode vectors, then randomized words and tokens
        dec_chk = 1'b1;
        bus_if.tmds_word = 10'h100; tick();
        bus_if.tmds_word = 10'h2FF; tick();
        chk("dec_100_data", {24'd0, bus_if.data}, 32'h00);
        chk("dec_100_de", {31'd0, bus_if.de}, 32'd1);
        bus_if.tmds_word = T11; tick();
        chk("dec_2ff_data", {24'd0, bus_if.data}, 32'hFE);
        bus_if.tmds_word = 10'h100; tick();
        chk("dec_t11_ctrl", {30'd0, bus_if.ctrl}, 32'd3);
        chk("dec_t11_de", {31'd0, bus_if.de}, 32'd0);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(3) == 0) bus_if.tmds_word = rotr(T00, 0) ^ (($urandom_range(1) == 1) ? 10'h3FF : 10'h000);
            else if ($urandom_range(7) == 0) bus_if.tmds_word = ($urandom_range(1) == 1) ? T11 : 10'b0101010100;
            else bus_if.tmds_word = rand_data_word();
            tick();
        end
        chk("dec_still_locked", {31'd0, bus_if.locked}, 32'd1);

        // loss of lock: refresh the run, then data only
        for (int k = 0; k < 8; k++) begin
            bus_if.tmds_word = T00;
            tick();
        end
        for (int j = 0; j < 4096; j++) begin
            bus_if.tmds_word = rand_data_word();
            tick();
        end
        chk("loss_hold", {31'd0, bus_if.locked}, 32'd1);
        bus_if.tmds_word = rand_data_word();
        tick();
        chk("loss_fall", {31'd0, bus_if.locked}, 32'd0);
        dec_chk = 1'b0;
        run_tokens_lock(T01, "relock");

        // alignment search: stream rotated by 3 bits, each bitslip removes one
        do_reset();
        n_slip = 0;
        slip_cyc.delete();
        off = 3;
        for (int i = 0; i < 9000 && !bus_if.locked; i++) begin
            bus_if.tmds_word = rotr(T00, off);
            prev = n_slip;
            tick();
            if (n_slip != prev && off > 0) off--;
        end
        chk("align_locked", {31'd0, bus_if.locked}, 32'd1);
        chk("align_slips", n_slip, 32'd3);
        for (int i = 1; i < slip_cyc.size(); i++)
            chk("slip_gap", slip_cyc[i] - slip_cyc[i-1], 32'd2065);
        repeat (20) tick();
        chk("align_no_extra_slip", n_slip, 32'd3);

        // reset in SETTLE, then a broken token run
        do_reset();
        n_slip = 0;
        for (int i = 0; i < 3000 && n_slip == 0; i++) begin
            bus_if.tmds_word = rand_data_word();
            tick();
        end
        chk("settle_reached", n_slip, 32'd1);
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_data", {24'd0, bus_if.data}, 32'd0);
        chk("rst_mid_ctrl", {30'd0, bus_if.ctrl}, 32'd0);
        chk("rst_mid_de", {31'd0, bus_if.de}, 32'd0);
        chk("rst_mid_ctrl_valid", {31'd0, bus_if.ctrl_valid}, 32'd0);
        chk("rst_mid_bitslip", {31'd0, bus_if.bitslip}, 32'd0);
        chk("rst_mid_locked", {31'd0, bus_if.locked}, 32'd0);
        do_reset();
        for (int k = 0; k < 7; k++) begin
            bus_if.tmds_word = T00;
            tick();
            chk("noise_nolock", {31'd0, bus_if.locked}, 32'd0);
        end
        bus_if.tmds_word = rand_data_word();
        tick();
        chk("noise_nolock", {31'd0, bus_if.locked}, 32'd0);
        run_tokens_lock(T00, "noise_lock");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
